// File: rtl/psw_pkg.sv
// Shared constants for the password attempt guard:
// FSM result codes and guard state encoding.
package psw_pkg;

  localparam logic [1:0] RES_NONE  = 2'b00;
  localparam logic [1:0] RES_GRANT = 2'b01;
  localparam logic [1:0] RES_DENY  = 2'b10;
  localparam logic [1:0] RES_RSVD  = 2'b11;

  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_OPEN    = 2'b01;
  localparam logic [1:0] ST_LOCKOUT = 2'b10;

  localparam int TIMER_W = 8;
  localparam int FAIL_W  = 4;

  function automatic logic is_quiet(
    input logic [1:0] r
  );
    return (r == RES_NONE) || (r == RES_RSVD);
  endfunction

endpackage

// File: rtl/psw_attempt_guard_if.sv
// Signal bundle between the password FSM side and
// the attempt guard.
interface psw_attempt_guard_if;
  import psw_pkg::*;

  logic                 tick;
  logic [1:0]           psw_result;
  logic                 enable_in;
  logic                 enable_out;
  logic                 door_open;
  logic                 locked;
  logic [FAIL_W-1:0]    fail_count;
  logic [TIMER_W-1:0]   lock_remaining;

  modport master (
    output tick,
    output psw_result,
    output enable_in,
    input  enable_out,
    input  door_open,
    input  locked,
    input  fail_count,
    input  lock_remaining
  );

  modport slave (
    input  tick,
    input  psw_result,
    input  enable_in,
    output enable_out,
    output door_open,
    output locked,
    output fail_count,
    output lock_remaining
  );

endinterface

// File: rtl/psw_result_edge.sv
// Turns the FSM result level into one-cycle grant/deny
// pulses; only a change out of a quiet code counts.
module psw_result_edge
  import psw_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] result_i,
  output logic       grant_ev_o,
  output logic       deny_ev_o
);

  logic [1:0] prev_q;
  logic [1:0] prev_d;

  assign prev_d = result_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= RES_NONE;
    end else begin
      prev_q <= prev_d;
    end
  end

  // 01<->10 swaps leave the quiet-prev test false,
  // so they never fire.
  assign grant_ev_o = is_quiet(prev_q) &&
                      (result_i == RES_GRANT);
  assign deny_ev_o  = is_quiet(prev_q) &&
                      (result_i == RES_DENY);

endmodule

// File: rtl/psw_attempt_guard.sv
// Counts consecutive denials, holds timed open and
// lockout windows, and gates the FSM enable meanwhile.
module psw_attempt_guard
  import psw_pkg::*;
#(
  parameter int MAX_FAILS  = 3,
  parameter int LOCK_TICKS = 30,
  parameter int OPEN_TICKS = 10
) (
  input logic               clk,
  input logic               rst,
  psw_attempt_guard_if.slave bus
);

  if (MAX_FAILS < 1 || MAX_FAILS > 15) begin : g_bad_fails
    $error("MAX_FAILS out of range");
  end
  if (LOCK_TICKS < 1 || LOCK_TICKS > 255) begin : g_bad_lock
    $error("LOCK_TICKS out of range");
  end
  if (OPEN_TICKS < 1 || OPEN_TICKS > 255) begin : g_bad_open
    $error("OPEN_TICKS out of range");
  end

  localparam logic [TIMER_W-1:0] OPEN_LD =
    TIMER_W'(OPEN_TICKS);
  localparam logic [TIMER_W-1:0] LOCK_LD =
    TIMER_W'(LOCK_TICKS);
  localparam logic [FAIL_W:0] FAIL_LIM =
    (FAIL_W+1)'(MAX_FAILS);

  logic [1:0]         state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [FAIL_W-1:0]  fail_q,  fail_d;
  logic [FAIL_W:0]    fail_inc;
  logic               grant_ev;
  logic               deny_ev;
  logic               expire;

  psw_result_edge u_edge (
    .clk        (clk),
    .rst        (rst),
    .result_i   (bus.psw_result),
    .grant_ev_o (grant_ev),
    .deny_ev_o  (deny_ev)
  );

  assign fail_inc = {1'b0, fail_q} + 1'b1;
  assign expire   = bus.tick &&
                    (timer_q == TIMER_W'(1));

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    fail_d  = fail_q;
    unique case (state_q)
      ST_IDLE: begin
        // Events win over tick here; tick has no
        // meaning while idle.
        if (grant_ev) begin
          state_d = ST_OPEN;
          timer_d = OPEN_LD;
          fail_d  = '0;
        end else if (deny_ev) begin
          if (fail_inc == FAIL_LIM) begin
            state_d = ST_LOCKOUT;
            timer_d = LOCK_LD;
            fail_d  = '0;
          end else begin
            fail_d  = fail_inc[FAIL_W-1:0];
          end
        end
      end
      ST_OPEN, ST_LOCKOUT: begin
        if (expire) begin
          state_d = ST_IDLE;
          timer_d = '0;
        end else if (bus.tick) begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
        fail_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      fail_q  <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      fail_q  <= fail_d;
    end
  end

  assign bus.door_open      = (state_q == ST_OPEN);
  assign bus.locked         = (state_q == ST_LOCKOUT);
  assign bus.fail_count     = fail_q;
  assign bus.lock_remaining =
    (state_q == ST_LOCKOUT) ? timer_q : '0;
  assign bus.enable_out     =
    (state_q == ST_IDLE) ? bus.enable_in : 1'b1;

endmodule

// File: tb/tb_psw_attempt_guard.sv
// Directed bench for psw_attempt_guard with
// hand-computed expectations at default parameters.
module tb_psw_attempt_guard;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  psw_attempt_guard_if bus ();

  psw_attempt_guard #(
    .MAX_FAILS  (3),
    .LOCK_TICKS (30),
    .OPEN_TICKS (10)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string tag,
    input int    got,
    input int    exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d",
               tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick1();
    bus.tick = 1'b1;
    cyc();
    bus.tick = 1'b0;
    cyc();
  endtask

  task automatic deny1();
    bus.psw_result = 2'b10;
    cyc();
    bus.psw_result = 2'b00;
    cyc();
  endtask

  initial begin
    bus.tick       = 1'b0;
    bus.psw_result = 2'b00;
    bus.enable_in  = 1'b0;
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;

    chk("rst_en",   bus.enable_out, 0);
    chk("rst_door", bus.door_open, 0);
    chk("rst_lock", bus.locked, 0);
    chk("rst_fail", bus.fail_count, 0);
    chk("rst_rem",  bus.lock_remaining, 0);
    bus.enable_in = 1'b1;
    #1;
    chk("idle_en_follow", bus.enable_out, 1);
    bus.enable_in = 1'b0;

    // grant and open window
    bus.psw_result = 2'b01;
    #1;
    chk("open_lat0", bus.door_open, 0);
    cyc();
    chk("open_door", bus.door_open, 1);
    chk("open_en",   bus.enable_out, 1);
    for (int i = 0; i < 10; i++) begin
      tick1();
      chk($sformatf("open_t%0d", i),
          bus.door_open, (i < 9) ? 1 : 0);
    end
    chk("open_en_back", bus.enable_out, 0);
    cyc();
    cyc();
    chk("open_no_reopen", bus.door_open, 0);
    // direct 01->10 is not a denial
    bus.psw_result = 2'b10;
    cyc();
    cyc();
    chk("swap_no_deny", bus.fail_count, 0);
    chk("swap_no_lock", bus.locked, 0);
    bus.psw_result = 2'b00;
    cyc();

    // three denials -> lockout
    deny1();
    chk("deny1", bus.fail_count, 1);
    deny1();
    chk("deny2", bus.fail_count, 2);
    bus.psw_result = 2'b10;
    cyc();
    chk("lock_on",   bus.locked, 1);
    chk("lock_rem",  bus.lock_remaining, 30);
    chk("lock_fail", bus.fail_count, 0);
    chk("lock_en",   bus.enable_out, 1);
    bus.psw_result = 2'b00;
    for (int i = 0; i < 30; i++) begin
      tick1();
      chk($sformatf("lock_rem_t%0d", i),
          bus.lock_remaining, 29 - i);
      chk($sformatf("lock_st_t%0d", i),
          bus.locked, (i < 29) ? 1 : 0);
    end
    chk("lock_end_fail", bus.fail_count, 0);

    // grant clears the denial run
    deny1();
    deny1();
    chk("pre_grant", bus.fail_count, 2);
    bus.psw_result = 2'b01;
    cyc();
    chk("grant_clr",  bus.fail_count, 0);
    chk("grant_door", bus.door_open, 1);
    bus.psw_result = 2'b00;
    for (int i = 0; i < 9; i++) tick1();
    // denial on the expiry cycle is dropped
    bus.psw_result = 2'b10;
    bus.tick = 1'b1;
    cyc();
    bus.tick = 1'b0;
    chk("exp_door", bus.door_open, 0);
    chk("exp_fail", bus.fail_count, 0);
    cyc();
    cyc();
    chk("exp_no_retrig", bus.fail_count, 0);
    bus.psw_result = 2'b00;
    cyc();
    deny1();
    chk("post_grant_deny", bus.fail_count, 1);
    deny1();
    chk("pre_tick_deny", bus.fail_count, 2);

    // tick and denial together in idle
    bus.psw_result = 2'b10;
    bus.tick = 1'b1;
    cyc();
    bus.tick = 1'b0;
    bus.psw_result = 2'b00;
    chk("tickdeny_lock", bus.locked, 1);
    chk("tickdeny_rem",  bus.lock_remaining, 30);
    for (int i = 0; i < 18; i++) tick1();
    chk("rem12", bus.lock_remaining, 12);

    // reset in the middle of lockout
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("mid_rst_lock", bus.locked, 0);
    chk("mid_rst_rem",  bus.lock_remaining, 0);
    chk("mid_rst_fail", bus.fail_count, 0);
    chk("mid_rst_en0",  bus.enable_out, 0);
    bus.enable_in = 1'b1;
    #1;
    chk("mid_rst_en1",  bus.enable_out, 1);
    cyc();
    chk("mid_rst_stay", bus.locked, 0);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=0 exp=1");
    $fatal(1, "timeout");
  end

endmodule
